// File: rtl/alu_sweep_if.sv
// Bus bundle between the ALU sweep checker (master) and the ALU and control logic (slave).
interface alu_sweep_if;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] alu_a;
   logic [2:0] alu_b;
   logic [1:0] alu_s;
   logic [4:0] alu_r;
   logic       alu_sf;
   logic       alu_zf;
   logic       alu_dzf;
   logic [7:0] vec_count;
   logic [7:0] err_count;
   logic       fail;
   logic [2:0] ff_a;
   logic [2:0] ff_b;
   logic [1:0] ff_s;
   logic [4:0] ff_r;

   modport master (
      input  start, alu_r, alu_sf, alu_zf, alu_dzf,
      output busy, done, alu_a, alu_b, alu_s,
      output vec_count, err_count, fail, ff_a, ff_b, ff_s, ff_r
   );

   modport slave (
      output start, alu_r, alu_sf, alu_zf, alu_dzf,
      input  busy, done, alu_a, alu_b, alu_s,
      input  vec_count, err_count, fail, ff_a, ff_b, ff_s, ff_r
   );
endinterface

// File: rtl/alu_sweep_checker.sv
// Exhaustive stimulus sweep and result checker for the 3-bit signed ALU.
// Optional macro ALU_CHK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module alu_sweep_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int MAX_MAG       = 3
) (
   input  logic        clk,
   input  logic        rst,
   alu_sweep_if.master bus
);
   typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_CHECK, ST_DONE} state_t;

   localparam logic [2:0] MAG_P  = 3'(MAX_MAG);
   localparam logic [2:0] MAG_N  = 3'(-MAX_MAG);
   localparam logic [7:0] CNT_HI = 8'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] a_q, a_d, b_q, b_d;
   logic [1:0] s_q, s_d;
   logic [7:0] vec_q, vec_d, err_q, err_d;
   logic       fail_q, fail_d;
   logic [2:0] ffa_q, ffa_d, ffb_q, ffb_d;
   logic [1:0] ffs_q, ffs_d;
   logic [4:0] ffr_q, ffr_d;

   logic signed [4:0] ra, rb, ref_r;
   logic              ref_dzf, mismatch, last_vec;

   // Reference model on sign-extended operands; % truncates, so the sign follows A.
   always_comb begin
      ra      = {{2{a_q[2]}}, a_q};
      rb      = {{2{b_q[2]}}, b_q};
      ref_r   = 5'sd0;
      ref_dzf = 1'b0;
      case (s_q)
         2'd0: ref_r = ra + rb;
         2'd1: ref_r = ra - rb;
         2'd2: ref_r = ra * rb;
         default: begin
            if (rb == 5'sd0) ref_dzf = 1'b1;
            else             ref_r   = ra % rb;
         end
      endcase
      mismatch = (bus.alu_r   != ref_r)          ||
                 (bus.alu_sf  != ref_r[4])       ||
                 (bus.alu_zf  != (ref_r == 5'sd0)) ||
                 (bus.alu_dzf != ref_dzf);
      last_vec = (a_q == MAG_P) && (b_q == MAG_P) && (s_q == 2'd3);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      vec_d   = vec_q;
      err_d   = err_q;
      fail_d  = fail_q;
      ffa_d   = ffa_q;
      ffb_d   = ffb_q;
      ffs_d   = ffs_q;
      ffr_d   = ffr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               vec_d   = 8'd0;
               err_d   = 8'd0;
               fail_d  = 1'b0;
               ffa_d   = 3'd0;
               ffb_d   = 3'd0;
               ffs_d   = 2'd0;
               ffr_d   = 5'd0;
               a_d     = MAG_N;
               b_d     = MAG_N;
               s_d     = 2'd0;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            cnt_d   = 8'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CNT_HI) state_d = ST_CHECK;
            else                 cnt_d   = cnt_q + 8'd1;
         end
         ST_CHECK: begin
            vec_d = vec_q + 8'd1;
            if (mismatch) begin
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               if (!fail_q) begin
                  fail_d = 1'b1;
                  ffa_d  = a_q;
                  ffb_d  = b_q;
                  ffs_d  = s_q;
                  ffr_d  = bus.alu_r;
               end
            end
            // S steps fastest, then B, then A.
            if (last_vec) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRIVE;
               if (s_q == 2'd3) begin
                  s_d = 2'd0;
                  if (b_q == MAG_P) begin
                     b_d = MAG_N;
                     a_d = a_q + 3'd1;
                  end else begin
                     b_d = b_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 2'd1;
               end
            end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
            if (mismatch && !fail_q) state_d = ST_DONE;
`else
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         a_q     <= 3'd0;
         b_q     <= 3'd0;
         s_q     <= 2'd0;
         vec_q   <= 8'd0;
         err_q   <= 8'd0;
         fail_q  <= 1'b0;
         ffa_q   <= 3'd0;
         ffb_q   <= 3'd0;
         ffs_q   <= 2'd0;
         ffr_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         ffa_q   <= ffa_d;
         ffb_q   <= ffb_d;
         ffs_q   <= ffs_d;
         ffr_q   <= ffr_d;
      end
   end

   assign bus.busy      = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.alu_s     = s_q;
   assign bus.vec_count = vec_q;
   assign bus.err_count = err_q;
   assign bus.fail      = fail_q;
   assign bus.ff_a      = ffa_q;
   assign bus.ff_b      = ffb_q;
   assign bus.ff_s      = ffs_q;
   assign bus.ff_r      = ffr_q;
endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench: a behavioural ALU with selectable faults feeds the sweep checker.
module tb_alu_sweep_checker;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   fault_mode = 0;   // 0 clean, 1 alu_r[0] stuck low, 2 alu_dzf stuck low

   alu_sweep_if bus ();

   alu_sweep_checker #(.SETTLE_CYCLES(2), .MAX_MAG(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic signed [4:0] ta, tb, tr;
   logic              tdz;
   always_comb begin
      ta  = {{2{bus.alu_a[2]}}, bus.alu_a};
      tb  = {{2{bus.alu_b[2]}}, bus.alu_b};
      tr  = 5'sd0;
      tdz = 1'b0;
      case (bus.alu_s)
         2'd0: tr = ta + tb;
         2'd1: tr = ta - tb;
         2'd2: tr = ta * tb;
         default: begin
            if (tb == 5'sd0) tdz = 1'b1;
            else             tr  = ta % tb;
         end
      endcase
      bus.alu_r = tr;
      if (fault_mode == 1) bus.alu_r[0] = 1'b0;
      bus.alu_sf  = tr[4];
      bus.alu_zf  = (tr == 5'sd0);
      bus.alu_dzf = (fault_mode == 2) ? 1'b0 : tdz;
   end

   // Pulses start, then counts busy cycles and done pulses until 4 cycles after done.
   task automatic run_sweep(input int start_at, input bit pulse_on_done,
                            output int busy_cyc, output int done_cnt, output bit timeout);
      int tail;
      busy_cyc = 0;
      done_cnt = 0;
      timeout  = 1'b1;
      tail     = -1;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            done_cnt++;
            timeout = 1'b0;
            if (tail < 0) tail = 4;
            if (pulse_on_done) bus.start = 1'b1;
         end
         if (i == start_at) bus.start = 1'b1;
         if (tail == 0) break;
         if (tail > 0) tail--;
         @(negedge clk);
         bus.start = 1'b0;
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      fault_mode = 0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.vec_count !== 8'd0) begin errors++; $display("FAIL reset_vec: got %0d want 0", bus.vec_count); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", bus.err_count); end
      checks++; if ({bus.fail, bus.ff_a, bus.ff_b, bus.ff_s, bus.ff_r} !== 14'd0) begin errors++; $display("FAIL reset_ff: got %b want 0", {bus.fail, bus.ff_a, bus.ff_b, bus.ff_s, bus.ff_r}); end
      checks++; if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 8'd0) begin errors++; $display("FAIL reset_alu: got %b want 0", {bus.alu_a, bus.alu_b, bus.alu_s}); end
      rst = 1'b0;
      @(negedge clk);
      $display("reset: checked");
   endtask

   task automatic test_vector_order();
      bit seen_done;
      seen_done = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         if (i == 0) begin
            checks++; if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 8'b101_101_00) begin errors++; $display("FAIL order_first: got %b want 10110100", {bus.alu_a, bus.alu_b, bus.alu_s}); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL order_busy: got %b want 1", bus.busy); end
         end
         if (i == 4) begin
            checks++; if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 8'b101_101_01) begin errors++; $display("FAIL order_second: got %b want 10110101", {bus.alu_a, bus.alu_b, bus.alu_s}); end
         end
         if (i == 16) begin
            checks++; if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 8'b101_110_00) begin errors++; $display("FAIL order_fifth: got %b want 10111000", {bus.alu_a, bus.alu_b, bus.alu_s}); end
         end
         if (bus.done) begin
            seen_done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL order_timeout: got no done want done"); end
      @(negedge clk);
      $display("vector_order: first vector %b", 8'b101_101_00);
   endtask

   task automatic test_clean_sweep();
      int bc, dc;
      bit to;
      fault_mode = 0;
      run_sweep(-1, 1'b0, bc, dc, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL clean_timeout: got timeout want done"); end
      checks++; if (bc !== 784) begin errors++; $display("FAIL clean_busy: got %0d want 784", bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL clean_done: got %0d want 1", dc); end
      checks++; if (bus.vec_count !== 8'd196) begin errors++; $display("FAIL clean_vec: got %0d want 196", bus.vec_count); end
      checks++; if (bus.err_count !== 8'd0) begin errors++; $display("FAIL clean_err: got %0d want 0", bus.err_count); end
      checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL clean_fail: got %b want 0", bus.fail); end
      $display("clean_sweep: busy=%0d vec=%0d err=%0d", bc, bus.vec_count, bus.err_count);
   endtask

   // Odd expected results: add 24, sub 24, mul 16, rem 12 -> 76. First odd one is (-3)*(-3)=9.
   task automatic test_r0_fault();
      int bc, dc;
      bit to;
      fault_mode = 1;
      run_sweep(-1, 1'b0, bc, dc, to);
      fault_mode = 0;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL r0_timeout: got timeout want done"); end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL r0_err: got %0d want 1", bus.err_count); end
      checks++; if (bus.vec_count !== 8'd3) begin errors++; $display("FAIL r0_vec: got %0d want 3", bus.vec_count); end
`else
      checks++; if (bus.err_count !== 8'd76) begin errors++; $display("FAIL r0_err: got %0d want 76", bus.err_count); end
      checks++; if (bus.vec_count !== 8'd196) begin errors++; $display("FAIL r0_vec: got %0d want 196", bus.vec_count); end
`endif
      checks++; if (bus.fail !== 1'b1) begin errors++; $display("FAIL r0_fail: got %b want 1", bus.fail); end
      checks++; if ({bus.ff_a, bus.ff_b, bus.ff_s} !== 8'b101_101_10) begin errors++; $display("FAIL r0_ffvec: got %b want 10110110", {bus.ff_a, bus.ff_b, bus.ff_s}); end
      checks++; if (bus.ff_r !== 5'b01000) begin errors++; $display("FAIL r0_ffr: got %b want 01000", bus.ff_r); end
      $display("r0_fault: err=%0d ff=%b/%b/%b r=%b", bus.err_count, bus.ff_a, bus.ff_b, bus.ff_s, bus.ff_r);
   endtask

   // Remainder by zero is vector 15 counting from 0 for A=-3, so 16 vectors are checked before it stops.
   task automatic test_dzf_fault();
      int bc, dc;
      bit to;
      fault_mode = 2;
      run_sweep(-1, 1'b0, bc, dc, to);
      fault_mode = 0;
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL dzf_timeout: got timeout want done"); end
`ifdef ALU_CHK_STOP_ON_FAIL_EN
      checks++; if (bus.err_count !== 8'd1) begin errors++; $display("FAIL dzf_err: got %0d want 1", bus.err_count); end
      checks++; if (bus.vec_count !== 8'd16) begin errors++; $display("FAIL dzf_vec: got %0d want 16", bus.vec_count); end
      checks++; if (bc !== 64) begin errors++; $display("FAIL dzf_busy: got %0d want 64", bc); end
`else
      checks++; if (bus.err_count !== 8'd7) begin errors++; $display("FAIL dzf_err: got %0d want 7", bus.err_count); end
      checks++; if (bus.vec_count !== 8'd196) begin errors++; $display("FAIL dzf_vec: got %0d want 196", bus.vec_count); end
`endif
      checks++; if ({bus.ff_a, bus.ff_b, bus.ff_s} !== 8'b101_000_11) begin errors++; $display("FAIL dzf_ffvec: got %b want 10100011", {bus.ff_a, bus.ff_b, bus.ff_s}); end
      checks++; if (bus.ff_r !== 5'b00000) begin errors++; $display("FAIL dzf_ffr: got %b want 00000", bus.ff_r); end
      $display("dzf_fault: err=%0d vec=%0d", bus.err_count, bus.vec_count);
   endtask

   task automatic test_start_while_busy();
      int bc, dc;
      bit to;
      run_sweep(100, 1'b0, bc, dc, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL swb_timeout: got timeout want done"); end
      checks++; if (bc !== 784) begin errors++; $display("FAIL swb_busy: got %0d want 784", bc); end
      checks++; if (bus.vec_count !== 8'd196) begin errors++; $display("FAIL swb_vec: got %0d want 196", bus.vec_count); end
      $display("start_while_busy: busy=%0d vec=%0d", bc, bus.vec_count);
   endtask

   task automatic test_back_to_back();
      int bc, dc;
      bit to;
      run_sweep(-1, 1'b1, bc, dc, to);
      checks++; if (bc !== 784) begin errors++; $display("FAIL b2b_busy: got %0d want 784", bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL b2b_done: got %0d want 1", dc); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", bus.busy); end
      run_sweep(-1, 1'b0, bc, dc, to);
      checks++; if (bc !== 784) begin errors++; $display("FAIL b2b_restart: got %0d want 784", bc); end
      $display("back_to_back: busy=%0d done=%0d", bc, dc);
   endtask

   task automatic test_reset_mid_sweep();
      int bc, dc, dpre;
      bit to;
      dpre = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (300) begin
         if (bus.done) dpre++;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      checks++; if ({bus.busy, bus.done, bus.fail} !== 3'b000) begin errors++; $display("FAIL rmid_ctrl: got %b want 000", {bus.busy, bus.done, bus.fail}); end
      checks++; if ({bus.vec_count, bus.err_count} !== 16'd0) begin errors++; $display("FAIL rmid_cnt: got %h want 0", {bus.vec_count, bus.err_count}); end
      checks++; if ({bus.alu_a, bus.alu_b, bus.alu_s} !== 8'd0) begin errors++; $display("FAIL rmid_alu: got %b want 0", {bus.alu_a, bus.alu_b, bus.alu_s}); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done) dpre++;
      end
      checks++; if (dpre !== 0) begin errors++; $display("FAIL rmid_nodone: got %0d want 0", dpre); end
      run_sweep(-1, 1'b0, bc, dc, to);
      checks++; if (bc !== 784) begin errors++; $display("FAIL rmid_busy: got %0d want 784", bc); end
      checks++; if ({bus.vec_count, bus.err_count} !== {8'd196, 8'd0}) begin errors++; $display("FAIL rmid_clean: got %0d/%0d want 196/0", bus.vec_count, bus.err_count); end
      $display("reset_mid_sweep: vec=%0d err=%0d", bus.vec_count, bus.err_count);
   endtask

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      test_reset();
      test_vector_order();
      test_clean_sweep();
      test_r0_fault();
      test_dzf_fault();
      test_clean_sweep();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
